// File: rtl/cache_axi_arbiter_pkg.sv
// Shared definitions for the cache-to-AXI-bridge arbiter: FSM state
// encodings, request type codes and requester IDs.
package cache_axi_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4
  } arb_state_t;

  // Anything other than TYPE_LINE is a single-word access.
  localparam logic [2:0] TYPE_LINE = 3'b100;

  // Requester IDs double as bit positions in the picker request vector.
  typedef enum logic [1:0] {
    ID_ICACHE = 2'd0,
    ID_DCACHE = 2'd1,
    ID_DCWR   = 2'd2
  } req_id_t;

  function automatic req_id_t onehot_to_id(input logic [2:0] grant);
    if (grant[2]) return ID_DCWR;
    if (grant[1]) return ID_DCACHE;
    return ID_ICACHE;
  endfunction

endpackage

// File: rtl/cache_axi_arbiter_picker.sv
// arb_picker3: three-way request picker with one-hot grant.
// Default build: fixed priority req[2] > req[1] > req[0].
// With CACHE_ARB_RR_EN defined: round-robin, the pointer moves to the
// candidate after the winner whenever a grant is taken (advance high).
module arb_picker3 (
`ifdef CACHE_ARB_RR_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
`endif
  input  logic [2:0] req,
  output logic [2:0] grant
);

`ifdef CACHE_ARB_RR_EN
  logic [1:0] ptr;
  logic [2:0] rot;
  logic [2:0] pick;

  // Rotate so the pointed-to candidate sits at bit 0, take the lowest set
  // bit, then rotate the pick back into requester positions.
  always_comb begin
    case (ptr)
      2'd1:    rot = {req[0], req[2:1]};
      2'd2:    rot = {req[1:0], req[2]};
      default: rot = req;
    endcase
    pick = rot & (~rot + 3'd1);
    case (ptr)
      2'd1:    grant = {pick[1:0], pick[2]};
      2'd2:    grant = {pick[0], pick[2:1]};
      default: grant = pick;
    endcase
  end

  // Pointer moves to the candidate after the winner on each taken grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd0;
    end else if (advance && (|req)) begin
      ptr <= grant[0] ? 2'd1 : (grant[1] ? 2'd2 : 2'd0);
    end
  end
`else
  // Fixed priority: dcache write, then dcache read, then icache read.
  always_comb begin
    grant[2] = req[2];
    grant[1] = req[1] & ~req[2];
    grant[0] = req[0] & ~req[1] & ~req[2];
  end
`endif

endmodule

// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: funnels icache reads, dcache reads and dcache writes
// onto a single-outstanding read/write bridge interface.
// Optional feature macro: CACHE_ARB_RR_EN (round-robin arbitration).
//
// state      | meaning
// IDLE       | arbitrate; latch winner's type/addr/strobe/data and ID
// RD_REQ     | m_rd_req held from latches until m_rd_rdy
// RD_DATA    | return beats forwarded to the granted read requester
// WR_REQ     | m_wr_req held from latches until m_wr_rdy
// WR_WAIT    | waiting for m_wr_done
module cache_axi_arbiter
  import cache_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_BEATS = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [1:0]              s_rd_req,
  input  logic [5:0]              s_rd_type,
  input  logic [2*ADDR_W-1:0]     s_rd_addr,
  output logic [1:0]              s_rd_rdy,
  output logic [1:0]              s_ret_valid,
  output logic                    s_ret_last,
  output logic [31:0]             s_ret_data,
  input  logic                    dc_wr_req,
  input  logic [2:0]              dc_wr_type,
  input  logic [ADDR_W-1:0]       dc_wr_addr,
  input  logic [3:0]              dc_wr_wstrb,
  input  logic [32*LINE_BEATS-1:0] dc_wr_data,
  output logic                    dc_wr_rdy,
  output logic                    dc_wr_done,
  output logic                    m_rd_req,
  output logic [2:0]              m_rd_type,
  output logic [ADDR_W-1:0]       m_rd_addr,
  input  logic                    m_rd_rdy,
  input  logic                    m_ret_valid,
  input  logic                    m_ret_last,
  input  logic [31:0]             m_ret_data,
  output logic                    m_wr_req,
  output logic [2:0]              m_wr_type,
  output logic [ADDR_W-1:0]       m_wr_addr,
  output logic [3:0]              m_wr_wstrb,
  output logic [32*LINE_BEATS-1:0] m_wr_data,
  input  logic                    m_wr_rdy,
  input  logic                    m_wr_done
);

  localparam logic [1:0] LAST_BEAT = 2'(LINE_BEATS - 1);

  arb_state_t              state;
  req_id_t                 grant_id;
  logic [2:0]              lat_type;
  logic [ADDR_W-1:0]       lat_addr;
  logic [3:0]              lat_wstrb;
  logic [32*LINE_BEATS-1:0] lat_data;
  logic [1:0]              beat_cnt;
  logic [2:0]              req_vec;
  logic [2:0]              grant;
  req_id_t                 win_id;

  assign req_vec = {dc_wr_req, s_rd_req};
  assign win_id  = onehot_to_id(grant);

  arb_picker3 u_picker (
`ifdef CACHE_ARB_RR_EN
    .clk     (aclk),
    .rst_n   (aresetn),
    .advance (state == ST_IDLE),
`endif
    .req     (req_vec),
    .grant   (grant)
  );

  // Bridge-side request fields come only from the latched transaction.
  assign m_rd_type  = lat_type;
  assign m_rd_addr  = lat_addr;
  assign m_wr_type  = lat_type;
  assign m_wr_addr  = lat_addr;
  assign m_wr_wstrb = lat_wstrb;
  assign m_wr_data  = lat_data;

  // Handshake pulses and return data pass straight through, gated by state.
  always_comb begin
    s_rd_rdy    = 2'b00;
    s_ret_valid = 2'b00;
    s_ret_last  = 1'b0;
    s_ret_data  = 32'd0;
    if (state == ST_RD_REQ && m_rd_rdy) begin
      s_rd_rdy = (grant_id == ID_DCACHE) ? 2'b10 : 2'b01;
    end
    if (state == ST_RD_DATA) begin
      if (m_ret_valid) begin
        s_ret_valid = (grant_id == ID_DCACHE) ? 2'b10 : 2'b01;
      end
      s_ret_last = m_ret_valid & m_ret_last;
      s_ret_data = m_ret_data;
    end
    dc_wr_rdy  = (state == ST_WR_REQ) && m_wr_rdy;
    dc_wr_done = (state == ST_WR_WAIT) && m_wr_done;
  end

  // Transaction FSM with latched request fields and registered bridge requests.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      grant_id  <= ID_ICACHE;
      lat_type  <= 3'd0;
      lat_addr  <= '0;
      lat_wstrb <= 4'd0;
      lat_data  <= '0;
      beat_cnt  <= 2'd0;
      m_rd_req  <= 1'b0;
      m_wr_req  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_vec) begin
            grant_id <= win_id;
            beat_cnt <= 2'd0;
            if (grant[2]) begin
              lat_type  <= dc_wr_type;
              lat_addr  <= dc_wr_addr;
              lat_wstrb <= dc_wr_wstrb;
              lat_data  <= dc_wr_data;
              m_wr_req  <= 1'b1;
              state     <= ST_WR_REQ;
            end else begin
              lat_type  <= grant[1] ? s_rd_type[5:3] : s_rd_type[2:0];
              lat_addr  <= grant[1] ? s_rd_addr[2*ADDR_W-1:ADDR_W]
                                    : s_rd_addr[ADDR_W-1:0];
              lat_wstrb <= 4'd0;
              lat_data  <= '0;
              m_rd_req  <= 1'b1;
              state     <= ST_RD_REQ;
            end
          end
        end
        ST_RD_REQ: begin
          if (m_rd_rdy) begin
            m_rd_req <= 1'b0;
            state    <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (m_ret_valid) begin
            beat_cnt <= beat_cnt + 2'd1;
            if (m_ret_last || (lat_type != TYPE_LINE) || (beat_cnt == LAST_BEAT)) begin
              state <= ST_IDLE;
            end
          end
        end
        ST_WR_REQ: begin
          if (m_wr_rdy) begin
            m_wr_req <= 1'b0;
            state    <= ST_WR_WAIT;
          end
        end
        ST_WR_WAIT: begin
          if (m_wr_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Bench for cache_axi_arbiter. Directed stimulus drives requesters and the
// bridge; expected handshake/return events go into a queue and a negedge
// monitor pops and compares whatever the DUT presents.
module tb_cache_axi_arbiter;

  localparam int ADDR_W = 32;
  localparam int LB     = 4;
  localparam logic [2:0] LINE = 3'b100;
  localparam logic [2:0] WORD = 3'b000;

  localparam logic [1:0] EV_RDRDY  = 2'd0;
  localparam logic [1:0] EV_RET    = 2'd1;
  localparam logic [1:0] EV_WRRDY  = 2'd2;
  localparam logic [1:0] EV_WRDONE = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  id;
    logic [31:0] data;
    logic        last;
  } evt_t;

  logic                 aclk, aresetn;
  logic [1:0]           s_rd_req;
  logic [5:0]           s_rd_type;
  logic [2*ADDR_W-1:0]  s_rd_addr;
  logic [1:0]           s_rd_rdy, s_ret_valid;
  logic                 s_ret_last;
  logic [31:0]          s_ret_data;
  logic                 dc_wr_req;
  logic [2:0]           dc_wr_type;
  logic [ADDR_W-1:0]    dc_wr_addr;
  logic [3:0]           dc_wr_wstrb;
  logic [32*LB-1:0]     dc_wr_data;
  logic                 dc_wr_rdy, dc_wr_done;
  logic                 m_rd_req;
  logic [2:0]           m_rd_type;
  logic [ADDR_W-1:0]    m_rd_addr;
  logic                 m_rd_rdy, m_ret_valid, m_ret_last;
  logic [31:0]          m_ret_data;
  logic                 m_wr_req;
  logic [2:0]           m_wr_type;
  logic [ADDR_W-1:0]    m_wr_addr;
  logic [3:0]           m_wr_wstrb;
  logic [32*LB-1:0]     m_wr_data;
  logic                 m_wr_rdy, m_wr_done;

  int   total = 0;
  int   bad   = 0;
  evt_t exp_q[$];

  cache_axi_arbiter #(.ADDR_W(ADDR_W), .LINE_BEATS(LB)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_rd_req(s_rd_req), .s_rd_type(s_rd_type), .s_rd_addr(s_rd_addr),
    .s_rd_rdy(s_rd_rdy), .s_ret_valid(s_ret_valid), .s_ret_last(s_ret_last),
    .s_ret_data(s_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
    .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data),
    .dc_wr_rdy(dc_wr_rdy), .dc_wr_done(dc_wr_done),
    .m_rd_req(m_rd_req), .m_rd_type(m_rd_type), .m_rd_addr(m_rd_addr),
    .m_rd_rdy(m_rd_rdy), .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last),
    .m_ret_data(m_ret_data),
    .m_wr_req(m_wr_req), .m_wr_type(m_wr_type), .m_wr_addr(m_wr_addr),
    .m_wr_wstrb(m_wr_wstrb), .m_wr_data(m_wr_data),
    .m_wr_rdy(m_wr_rdy), .m_wr_done(m_wr_done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, got, want);
    end
  endtask

  function automatic evt_t mk(input logic [1:0] k, input logic [1:0] id,
                              input logic [31:0] d, input logic l);
    evt_t e;
    e.kind = k; e.id = id; e.data = d; e.last = l;
    return e;
  endfunction

  function automatic logic [1:0] id_of(input logic [1:0] v);
    if (v == 2'b01) return 2'd0;
    if (v == 2'b10) return 2'd1;
    return 2'd3;
  endfunction

  task automatic push(input logic [1:0] k, input logic [1:0] id,
                      input logic [31:0] d, input logic l);
    exp_q.push_back(mk(k, id, d, l));
  endtask

  task automatic observe(input evt_t got);
    evt_t want;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d id=%0d data=%h last=%0d, required no event",
               got.kind, got.id, got.data, got.last);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        bad++;
        $display("FAIL event: got kind=%0d id=%0d data=%h last=%0d, required kind=%0d id=%0d data=%h last=%0d",
                 got.kind, got.id, got.data, got.last, want.kind, want.id, want.data, want.last);
      end
    end
  endtask

  // Monitor: every presented handshake or return beat must match the queue head.
  always @(negedge aclk) begin
    if (aresetn === 1'b1) begin
      if (s_rd_rdy != 2'b00)    observe(mk(EV_RDRDY, id_of(s_rd_rdy), 32'd0, 1'b0));
      if (s_ret_valid != 2'b00) observe(mk(EV_RET, id_of(s_ret_valid), s_ret_data, s_ret_last));
      if (dc_wr_rdy)            observe(mk(EV_WRRDY, 2'd0, 32'd0, 1'b0));
      if (dc_wr_done)           observe(mk(EV_WRDONE, 2'd0, 32'd0, 1'b0));
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic raise_rd(input int id, input logic [2:0] typ, input logic [31:0] addr);
    s_rd_req[id] = 1'b1;
    s_rd_type[id*3 +: 3] = typ;
    s_rd_addr[id*ADDR_W +: ADDR_W] = addr;
  endtask

  task automatic raise_wr(input logic [2:0] typ, input logic [31:0] addr,
                          input logic [3:0] strb, input logic [127:0] data);
    dc_wr_req = 1'b1; dc_wr_type = typ; dc_wr_addr = addr;
    dc_wr_wstrb = strb; dc_wr_data = data;
  endtask

  task automatic serve_rd(input int id, input logic [2:0] typ, input logic [31:0] addr,
                          input int delay, input int nbeats, input logic [31:0] base,
                          input bit use_last, input bit keep, input bit spurious,
                          output int waited);
    waited = 0;
    while (m_rd_req !== 1'b1 && waited < 20) begin tick(); waited++; end
    chk("m_rd_req_seen", m_rd_req, 1);
    chk("m_rd_addr", m_rd_addr, addr);
    chk("m_rd_type", m_rd_type, typ);
    push(EV_RDRDY, 2'(id), 32'd0, 1'b0);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("m_rd_addr_hold", m_rd_addr, addr);
    end
    m_rd_rdy = 1'b1;
    tick();
    m_rd_rdy = 1'b0;
    if (!keep) s_rd_req[id] = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      push(EV_RET, 2'(id), base + 32'(b), use_last && (b == nbeats - 1));
      m_ret_valid = 1'b1;
      m_ret_data  = base + 32'(b);
      m_ret_last  = use_last && (b == nbeats - 1);
      tick();
    end
    m_ret_valid = 1'b0; m_ret_last = 1'b0;
    if (spurious) begin
      m_ret_valid = 1'b1; m_ret_data = 32'hDEAD_BEEF;
      tick();
      m_ret_valid = 1'b0;
    end
  endtask

  task automatic serve_wr(input logic [2:0] typ, input logic [31:0] addr,
                          input logic [3:0] strb, input logic [127:0] data,
                          input int delay, input int done_delay, input bit keep,
                          output int waited);
    waited = 0;
    while (m_wr_req !== 1'b1 && waited < 20) begin tick(); waited++; end
    chk("m_wr_req_seen", m_wr_req, 1);
    chk("m_wr_addr", m_wr_addr, addr);
    chk("m_wr_type", m_wr_type, typ);
    chk("m_wr_wstrb", m_wr_wstrb, strb);
    chk("m_wr_data", m_wr_data, data);
    push(EV_WRRDY, 2'd0, 32'd0, 1'b0);
    repeat (delay) tick();
    m_wr_rdy = 1'b1;
    tick();
    m_wr_rdy = 1'b0;
    if (!keep) dc_wr_req = 1'b0;
    repeat (done_delay) tick();
    push(EV_WRDONE, 2'd0, 32'd0, 1'b0);
    m_wr_done = 1'b1;
    tick();
    m_wr_done = 1'b0;
  endtask

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: run still active at 100000 ns, required completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    logic [127:0] ldata;
    aresetn = 1'b0;
    s_rd_req = '0; s_rd_type = '0; s_rd_addr = '0;
    dc_wr_req = 1'b0; dc_wr_type = '0; dc_wr_addr = '0; dc_wr_wstrb = '0; dc_wr_data = '0;
    m_rd_rdy = 1'b0; m_ret_valid = 1'b1; m_ret_last = 1'b1; m_ret_data = 32'h5555_AAAA;
    m_wr_rdy = 1'b0; m_wr_done = 1'b1;
    repeat (3) tick();
    chk("rst_m_rd_req", m_rd_req, 0);
    chk("rst_m_wr_req", m_wr_req, 0);
    chk("rst_s_ret", {s_ret_valid, s_ret_last, s_ret_data}, 0);
    chk("rst_wr_done", dc_wr_done, 0);
    chk("rst_m_rd_addr", m_rd_addr, 0);
    m_ret_valid = 1'b0; m_ret_last = 1'b0; m_ret_data = '0; m_wr_done = 1'b0;
    aresetn = 1'b1;
    tick();

    // icache line read with last on beat 4
    raise_rd(0, LINE, 32'h1C00_0000);
    serve_rd(0, LINE, 32'h1C00_0000, 0, 4, 32'h1111_0000, 1, 0, 0, w);
    chk("icache_grant_latency", w, 1);
    tick();
    chk("idle_after_line", m_rd_req, 0);

    // dcache word read, bridge accept delayed 5 cycles
    raise_rd(1, WORD, 32'h0000_2004);
    serve_rd(1, WORD, 32'h0000_2004, 5, 1, 32'hCAFE_0001, 0, 0, 1, w);

    // line read ended by beat count (no last from bridge)
    raise_rd(1, LINE, 32'h0000_3000);
    serve_rd(1, LINE, 32'h0000_3000, 1, 4, 32'h3333_0000, 0, 0, 1, w);

    // line read ended early by m_ret_last on beat 2
    raise_rd(0, LINE, 32'h0000_4000);
    serve_rd(0, LINE, 32'h0000_4000, 1, 2, 32'h4444_0000, 1, 0, 1, w);

    // simultaneous line write and dcache read
    ldata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    raise_wr(LINE, 32'h0000_1000, 4'hF, ldata);
    raise_rd(1, WORD, 32'h0000_5000);
`ifdef CACHE_ARB_RR_EN
    serve_rd(1, WORD, 32'h0000_5000, 0, 1, 32'h5555_0000, 0, 0, 0, w);
    chk("rr_first_gap", w, 1);
    serve_wr(LINE, 32'h0000_1000, 4'hF, ldata, 0, 2, 0, w);
    chk("rr_second_gap", w, 1);
`else
    serve_wr(LINE, 32'h0000_1000, 4'hF, ldata, 2, 3, 0, w);
    chk("wr_first_latency", w, 1);
    serve_rd(1, WORD, 32'h0000_5000, 0, 1, 32'h5555_0000, 0, 0, 0, w);
    chk("one_idle_gap", w, 1);
`endif

    // spurious m_wr_done and m_ret_valid while idle
    tick();
    m_wr_done = 1'b1; m_ret_valid = 1'b1; m_ret_data = 32'h7777_7777;
    #2;
    chk("spurious_wr_done", dc_wr_done, 0);
    chk("spurious_ret_valid", s_ret_valid, 0);
    tick();
    m_wr_done = 1'b0; m_ret_valid = 1'b0;
    chk("spurious_no_state_change", {m_rd_req, m_wr_req}, 0);

    // word write with partial strobe
    raise_wr(WORD, 32'h0000_6008, 4'b0110, {96'd0, 32'h1234_5678});
    serve_wr(WORD, 32'h0000_6008, 4'b0110, {96'd0, 32'h1234_5678}, 1, 0, 0, w);

    // reset in the middle of a line return
    tick();
    raise_rd(0, LINE, 32'h0000_7000);
    w = 0;
    while (m_rd_req !== 1'b1 && w < 20) begin tick(); w++; end
    chk("rst_case_req", m_rd_req, 1);
    push(EV_RDRDY, 2'd0, 32'd0, 1'b0);
    m_rd_rdy = 1'b1;
    tick();
    m_rd_rdy = 1'b0; s_rd_req[0] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      push(EV_RET, 2'd0, 32'h7000_0000 + 32'(b), 1'b0);
      m_ret_valid = 1'b1; m_ret_data = 32'h7000_0000 + 32'(b);
      tick();
    end
    m_ret_data = 32'h7000_0002;
    aresetn = 1'b0;
    #2;
    chk("midrst_s_ret", {s_ret_valid, s_ret_last, s_ret_data}, 0);
    chk("midrst_m_rd", {m_rd_req, m_rd_type, m_rd_addr}, 0);
    tick();
    chk("midrst_outs", {s_rd_rdy, dc_wr_rdy, dc_wr_done, m_wr_req, s_ret_valid}, 0);
    m_ret_valid = 1'b0;
    aresetn = 1'b1;
    tick();
    chk("post_rst_idle", {m_rd_req, m_wr_req}, 0);

`ifdef CACHE_ARB_RR_EN
    // all three requesting continuously: rotation from a cleared pointer
    raise_rd(0, WORD, 32'h0000_0100);
    raise_rd(1, WORD, 32'h0000_0200);
    raise_wr(WORD, 32'h0000_0300, 4'h3, {96'd0, 32'hABCD_0300});
    serve_rd(0, WORD, 32'h0000_0100, 0, 1, 32'h0100_0001, 0, 1, 0, w);
    serve_rd(1, WORD, 32'h0000_0200, 0, 1, 32'h0200_0001, 0, 1, 0, w);
    serve_wr(WORD, 32'h0000_0300, 4'h3, {96'd0, 32'hABCD_0300}, 0, 0, 1, w);
    serve_rd(0, WORD, 32'h0000_0100, 0, 1, 32'h0100_0002, 0, 0, 0, w);
    serve_rd(1, WORD, 32'h0000_0200, 0, 1, 32'h0200_0002, 0, 0, 0, w);
    serve_wr(WORD, 32'h0000_0300, 4'h3, {96'd0, 32'hABCD_0300}, 0, 0, 0, w);
`else
    // all three at once: write, then dcache read, then icache read
    raise_rd(0, WORD, 32'h0000_0100);
    raise_rd(1, WORD, 32'h0000_0200);
    raise_wr(WORD, 32'h0000_0300, 4'h3, {96'd0, 32'hABCD_0300});
    serve_wr(WORD, 32'h0000_0300, 4'h3, {96'd0, 32'hABCD_0300}, 0, 0, 0, w);
    serve_rd(1, WORD, 32'h0000_0200, 0, 1, 32'h0200_0001, 0, 0, 0, w);
    serve_rd(0, WORD, 32'h0000_0100, 0, 1, 32'h0100_0001, 0, 0, 0, w);
`endif

    repeat (3) tick();
    chk("expected_queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
